mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single data-memory port. It sits between instruction fetch (port 0, read-only) and load/store (port 1, read/write) on one side and the data memory on the other. It grants one request at a time using round-robin priority and drives the memory's registered read port. It also enforces the memory's write timing: the write strobe is registered inside the memory, so the write address, data and mask must stay stable for the strobe cycle and the following cycle.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares one data-memory port between
// instruction fetch (port 0, read-only) and load/store (port 1).
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_m0_req_valid,
  output logic          o_m0_req_ready,
  input  logic [AW-1:0] i_m0_req_addr,
  output logic          o_m0_resp_valid,
  output logic [DW-1:0] o_m0_resp_rdata,
  input  logic          i_m1_req_valid,
  output logic          o_m1_req_ready,
  input  logic          i_m1_req_wen,
  input  logic [AW-1:0] i_m1_req_addr,
  input  logic [DW-1:0] i_m1_req_wdata,
  input  logic [2:0]    i_m1_req_wmask,
  output logic          o_m1_resp_valid,
  output logic [DW-1:0] o_m1_resp_rdata,
  output logic          o_mem_wen,
  output logic [AW-1:0] o_mem_raddr,
  output logic [AW-1:0] o_mem_waddr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [2:0]    o_mem_wmask,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR_EN,
    WR_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_port;
  logic [AW-1:0] r_mem_raddr;
  logic [AW-1:0] r_mem_waddr;
  logic [DW-1:0] r_mem_wdata;
  logic [2:0]    r_mem_wmask;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_acc_rd;
  logic w_acc_wr;
  logic w_rd_data0;
  logic w_rd_data1;

  // On a tie the port that lost the previous arbitration wins this one.
  always_comb begin
    w_grant0   = i_m0_req_valid & (~i_m1_req_valid | r_last_grant);
    w_grant1   = i_m1_req_valid & (~i_m0_req_valid | ~r_last_grant);
    w_acc0     = (r_state == IDLE) & w_grant0;
    w_acc1     = (r_state == IDLE) & w_grant1;
    w_acc_wr   = w_acc1 & i_m1_req_wen;
    w_acc_rd   = w_acc0 | (w_acc1 & ~i_m1_req_wen);
    w_rd_data0 = (r_state == RD_DATA) & ~r_port;
    w_rd_data1 = (r_state == RD_DATA) & r_port;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc_wr) begin
          w_next = WR_EN;
        end else if (w_acc_rd) begin
          w_next = RD_ISSUE;
        end
      end
      RD_ISSUE: w_next = RD_DATA;
      RD_DATA:  w_next = IDLE;
      WR_EN:    w_next = WR_HOLD;
      WR_HOLD:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc0 | w_acc1) begin
        r_last_grant <= w_acc1;
        r_port       <= w_acc1;
      end
    end
  end

  // Write address/data/mask are only reloaded on a store acceptance so they
  // stay stable through the memory's delayed commit and across later reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_raddr <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else begin
      if (w_acc_rd) begin
        r_mem_raddr <= w_acc0 ? i_m0_req_addr : i_m1_req_addr;
      end
      if (w_acc_wr) begin
        r_mem_waddr <= i_m1_req_addr;
        r_mem_wdata <= i_m1_req_wdata;
        r_mem_wmask <= i_m1_req_wmask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_rd_data0) begin
        r_m0_rdata <= i_mem_rdata;
      end
      if (w_rd_data1) begin
        r_m1_rdata <= i_mem_rdata;
      end else if (r_state == WR_HOLD) begin
        r_m1_rdata <= '0;
      end
    end
  end

  // Read data bypasses the capture register in the response cycle itself.
  always_comb begin
    o_m0_req_ready  = w_acc0;
    o_m1_req_ready  = w_acc1;
    o_m0_resp_valid = w_rd_data0;
    o_m1_resp_valid = w_rd_data1 | (r_state == WR_HOLD);
    o_m0_resp_rdata = w_rd_data0 ? i_mem_rdata : r_m0_rdata;
    o_m1_resp_rdata = w_rd_data1 ? i_mem_rdata :
                      (r_state == WR_HOLD) ? '0 : r_m1_rdata;
    o_mem_wen       = (r_state == WR_EN);
    o_mem_raddr     = r_mem_raddr;
    o_mem_waddr     = r_mem_waddr;
    o_mem_wdata     = r_mem_wdata;
    o_mem_wmask     = r_mem_wmask;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level timing model and reference memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0ReqValid;
  logic        m0ReqReady;
  logic [31:0] m0ReqAddr;
  logic        m0RespValid;
  logic [31:0] m0RespRdata;
  logic        m1ReqValid;
  logic        m1ReqReady;
  logic        m1ReqWen;
  logic [31:0] m1ReqAddr;
  logic [31:0] m1ReqWdata;
  logic [2:0]  m1ReqWmask;
  logic        m1RespValid;
  logic [31:0] m1RespRdata;
  logic        memWen;
  logic [31:0] memRaddr;
  logic [31:0] memWaddr;
  logic [31:0] memWdata;
  logic [2:0]  memWmask;
  logic [31:0] memRdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_m0_req_valid (m0ReqValid),
    .o_m0_req_ready (m0ReqReady),
    .i_m0_req_addr  (m0ReqAddr),
    .o_m0_resp_valid(m0RespValid),
    .o_m0_resp_rdata(m0RespRdata),
    .i_m1_req_valid (m1ReqValid),
    .o_m1_req_ready (m1ReqReady),
    .i_m1_req_wen   (m1ReqWen),
    .i_m1_req_addr  (m1ReqAddr),
    .i_m1_req_wdata (m1ReqWdata),
    .i_m1_req_wmask (m1ReqWmask),
    .o_m1_resp_valid(m1RespValid),
    .o_m1_resp_rdata(m1RespRdata),
    .o_mem_wen      (memWen),
    .o_mem_raddr    (memRaddr),
    .o_mem_waddr    (memWaddr),
    .o_mem_wdata    (memWdata),
    .o_mem_wmask    (memWmask),
    .i_mem_rdata    (memRdata)
  );

  function automatic logic [31:0] initWord(input int i);
    return (i == 0) ? 32'h0000_0413 : ((32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678);
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Data memory: registered read port, write strobe delayed one cycle and
  // committed with the address/data present during the following cycle.
  logic [31:0] memArr [0:255];
  logic        memWenD;
  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = initWord(i);
    memWenD = 1'b0;
    forever begin
      @(posedge clk);
      memRdata <= memArr[wordIdx(memRaddr)];
      if (memWenD) memArr[wordIdx(memWaddr)] = memWdata;
      memWenD = memWen;
    end
  end

  int compareCount = 0;
  int mismatchCount = 0;
  int cycleNum = 0;

  logic [31:0] refMem [0:255];
  bit          pending;
  int          age;
  bit          tPort;
  bit          tWen;
  logic [31:0] tAddr;
  logic [31:0] tWdata;
  bit          lastGrant;
  logic [31:0] expRaddr;
  logic [31:0] expWaddr;
  logic [31:0] expWdata;
  logic [2:0]  expWmask;
  logic [31:0] holdM0;
  logic [31:0] holdM1;
  int          acceptLog[$];
  int          acceptCycles[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycleNum, obs, exp);
    end
  endtask

  task automatic modelReset();
    pending   = 0;
    age       = 0;
    lastGrant = 1;
    expRaddr  = '0;
    expWaddr  = '0;
    expWdata  = '0;
    expWmask  = '0;
    holdM0    = '0;
    holdM1    = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Rdy0"}, 32'(m0ReqReady), 32'd0);
    checkOutput({tag, "Rdy1"}, 32'(m1ReqReady), 32'd0);
    checkOutput({tag, "Vld0"}, 32'(m0RespValid), 32'd0);
    checkOutput({tag, "Vld1"}, 32'(m1RespValid), 32'd0);
    checkOutput({tag, "Rd0"}, m0RespRdata, 32'd0);
    checkOutput({tag, "Rd1"}, m1RespRdata, 32'd0);
    checkOutput({tag, "Wen"}, 32'(memWen), 32'd0);
    checkOutput({tag, "Raddr"}, memRaddr, 32'd0);
    checkOutput({tag, "Waddr"}, memWaddr, 32'd0);
    checkOutput({tag, "Wdata"}, memWdata, 32'd0);
    checkOutput({tag, "Wmask"}, 32'(memWmask), 32'd0);
  endtask

  // Called at a rising edge; asserts reset, holds it for holdCycles edges.
  task automatic resetPulse(input int holdCycles);
    #1;
    rst = 1'b1;
    m0ReqValid = 1'b0;
    m1ReqValid = 1'b0;
    #1;
    modelReset();
    checkAllZero("rst");
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      cycleNum++;
      #2;
      checkAllZero("rstHeld");
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    cycleNum++;
  endtask

  // One clock cycle: drive inputs, compare every output with the model's
  // expectation for this cycle, then advance the model across the edge.
  task automatic applyStimulus(input bit v0, input logic [31:0] a0, input bit v1,
                               input bit w1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic [2:0] m1);
    bit          expR0;
    bit          expR1;
    bit          respNow;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
    logic [31:0] readVal;
    #1;
    m0ReqValid = v0;
    m0ReqAddr  = a0;
    m1ReqValid = v1;
    m1ReqWen   = w1;
    m1ReqAddr  = a1;
    m1ReqWdata = d1;
    m1ReqWmask = m1;
    #1;
    expR0   = !pending && v0 && (!v1 || lastGrant);
    expR1   = !pending && v1 && (!v0 || !lastGrant);
    respNow = pending && (age == 2);
    readVal = refMem[wordIdx(tAddr)];
    expRd0  = (respNow && !tPort) ? readVal : holdM0;
    expRd1  = (respNow && tPort) ? (tWen ? 32'd0 : readVal) : holdM1;

    checkOutput("rdy0", 32'(m0ReqReady), 32'(expR0));
    checkOutput("rdy1", 32'(m1ReqReady), 32'(expR1));
    checkOutput("vld0", 32'(m0RespValid), 32'(respNow && !tPort));
    checkOutput("vld1", 32'(m1RespValid), 32'(respNow && tPort));
    checkOutput("rdata0", m0RespRdata, expRd0);
    checkOutput("rdata1", m1RespRdata, expRd1);
    checkOutput("memWen", 32'(memWen), 32'(pending && age == 1 && tWen));
    checkOutput("raddr", memRaddr, expRaddr);
    checkOutput("waddr", memWaddr, expWaddr);
    checkOutput("wdata", memWdata, expWdata);
    checkOutput("wmask", 32'(memWmask), 32'(expWmask));

    if (respNow) begin
      if (!tPort) holdM0 = expRd0;
      else        holdM1 = expRd1;
      if (tWen) refMem[wordIdx(tAddr)] = tWdata;
    end
    if (pending) begin
      age++;
      if (age == 3) pending = 0;
    end else if (expR0 || expR1) begin
      pending   = 1;
      age       = 1;
      tPort     = expR1;
      tWen      = expR1 && w1;
      tAddr     = expR1 ? a1 : a0;
      tWdata    = d1;
      lastGrant = tPort;
      if (tWen) begin
        expWaddr = a1;
        expWdata = d1;
        expWmask = m1;
      end else begin
        expRaddr = tAddr;
      end
      acceptLog.push_back(int'(tPort));
      acceptCycles.push_back(cycleNum);
    end
    @(posedge clk);
    cycleNum++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, $urandom, 1'b0, 1'($urandom), $urandom, $urandom, 3'($urandom));
  endtask

  function automatic logic [31:0] randAddr();
    return 32'h8000_0000 | ($urandom & 32'h0000_03FC);
  endfunction

  initial begin
    int base;
    int got;
    rst        = 1'b1;
    m0ReqValid = 1'b0;
    m0ReqAddr  = '0;
    m1ReqValid = 1'b0;
    m1ReqWen   = 1'b0;
    m1ReqAddr  = '0;
    m1ReqWdata = '0;
    m1ReqWmask = '0;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    modelReset();
    @(posedge clk);
    resetPulse(2);
    idleCycles(3);

    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, '0, '0, 3'b000);
    idleCycles(3);

    $display("[TB] store, input churn, load back");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 3'b100);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h8000_0204, 32'h1111_2222, 3'b010);
    idleCycles(2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h8000_0100, 32'h5555_AAAA, 3'b001);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h8000_0008, 32'h3333_4444, 3'b011);
    idleCycles(2);
    checkOutput("loadBack", holdM1, 32'hDEAD_BEEF);

    $display("[TB] idle");
    idleCycles(10);

    $display("[TB] reset during read data");
    applyStimulus(1'b1, randAddr(), 1'b0, 1'b0, '0, '0, 3'b000);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    resetPulse(2);

    $display("[TB] tie arbitration");
    base = acceptLog.size();
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, randAddr(), 1'b1, 1'($urandom), randAddr(), $urandom, 3'($urandom));
    got = acceptLog.size() - base;
    checkOutput("tieCount", 32'(got), 32'd4);
    for (int k = 0; k < got && k < 4; k++) begin
      checkOutput("tieOrder", 32'(acceptLog[base + k]), 32'(k % 2));
      if (k > 0)
        checkOutput("tieGap", 32'(acceptCycles[base + k] - acceptCycles[base + k - 1]), 32'd3);
    end
    idleCycles(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom % 10) < 6, randAddr(), ($urandom % 10) < 6,
                    1'($urandom), randAddr(), $urandom, 3'($urandom));
    idleCycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
